i2c_sensor_seq: RTL and testbench
=================================

I2C_SENSOR_SEQ -- requirements
Module: i2c_sensor_seq

Interface
REQ-001 SHALL expose parameter SLAVE_ADDR, default 7'h44: 7-bit target device address.
REQ-002 SHALL expose parameter MEAS_CMD, default 16'h2C06: 16-bit measurement command word.
REQ-003 SHALL expose parameter RD_BYTES, default 3'd2: read length in bytes, legal range 1..2.
REQ-004 SHALL expose parameter CONV_CYCLES, default 16'd6000: clk cycles between command-write completion and read start.
REQ-005 SHALL expose parameter PERIOD_CYCLES, default 24'd5000000: clk cycles from one result to the next measurement start.
REQ-006 SHALL expose parameter MAX_RETRY, default 2'd2: NACK retries per phase.
REQ-007 SHALL expose ports as follows (one clock; reset is synchronous and active-low):
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- enable  in  1  level; 1 = run periodic measurements.
- i2c_ready  in  1  master idle and able to accept i2c_start.
- i2c_done  in  1  one-cycle pulse: master transaction finished.
- i2c_nack  in  1  valid with i2c_done; 1 = slave NACKed.
- i2c_rdata  in  16  read data, valid with i2c_done; first byte in [15:8].
- i2c_start  out  1  one-cycle transaction request.
- slave_addr  out  7  target address.
- cmd_byte  out  1  1 = write i2c_cmd, 0 = read.
- i2c_cmd  out  16  command word.
- data_byte  out  3  read byte count.
- bin  out  16  last good result.
- bin_valid  out  1  one-cycle pulse on bin update.
- busy  out  1  1 in every state except IDLE.
- flag  out  2  status: 00 ok, 01 retrying, 10 error.

Function
REQ-008 SHALL implement FSM states IDLE, WR_REQ, WR_WAIT, CONV, RD_REQ, RD_WAIT, UPDATE, PERIOD.
REQ-009 IDLE: enable=1 SHALL move to WR_REQ next cycle and clear the retry counter.
REQ-010 WR_REQ: i2c_start SHALL pulse for exactly one cycle, only when i2c_ready=1, with cmd_byte=1 and i2c_cmd=MEAS_CMD; then move to WR_WAIT. With i2c_ready=0 the FSM SHALL hold and i2c_start SHALL stay 0.
REQ-011 slave_addr, cmd_byte, i2c_cmd and data_byte SHALL be registered and stable from the i2c_start cycle through the matching i2c_done.
REQ-012 WR_WAIT on i2c_done:
- i2c_nack=0: SHALL load the delay counter and move to CONV.
- i2c_nack=1 and retries<MAX_RETRY: SHALL increment retries, set flag=01, return to WR_REQ.
- i2c_nack=1 otherwise: SHALL set flag=10 and go to PERIOD.
REQ-013 CONV SHALL last exactly CONV_CYCLES cycles, then move to RD_REQ with retries cleared. CONV_CYCLES=0 SHALL behave as 1.
REQ-014 RD_REQ/RD_WAIT SHALL mirror REQ-010/012 with cmd_byte=0 and data_byte=RD_BYTES. On a good read the FSM SHALL go to UPDATE. A final NACK SHALL set flag=10 and go to PERIOD.
REQ-015 UPDATE (one cycle): bin SHALL load i2c_rdata captured at i2c_done (RD_BYTES=1: bin={8'h00,rdata[15:8]}). bin_valid SHALL pulse, flag SHALL return to 00, and the FSM SHALL move to PERIOD.
REQ-016 PERIOD SHALL count PERIOD_CYCLES cycles, then go to WR_REQ if enable=1, else IDLE.
REQ-017 enable=0 mid-sequence SHALL NOT abort: the current transaction completes; any state other than a WAIT state SHALL go to IDLE on the next cycle; bin SHALL be kept.
REQ-018 i2c_done outside WR_WAIT/RD_WAIT SHALL be ignored. i2c_nack without i2c_done SHALL be ignored.
REQ-019 Counters SHALL saturate, never wrap. The retry counter SHALL be 2 bits.

Reset
REQ-020 With rst=0 at a clk edge, the block SHALL enter IDLE and drive: i2c_start=0, bin_valid=0, busy=0, flag=00, bin=16'h0000, cmd_byte=0, i2c_cmd=16'h0000, data_byte=0, slave_addr=SLAVE_ADDR. All counters SHALL clear.
REQ-021 Reset mid-transaction SHALL take effect next edge; a later stray i2c_done SHALL be ignored per REQ-018.

Verification (CONV_CYCLES=4, PERIOD_CYCLES=20, MAX_RETRY=2)
REQ-022 Nominal: enable=1, ready=1, done/nack=0 after 10 cycles, rdata=16'h6A3C -> one write start (cmd 16'h2C06), read start exactly 4 cycles after write done, bin=16'h6A3C, single bin_valid pulse, next write start 20 cycles later.
REQ-023 Ready stall: i2c_ready=0 for 15 cycles in WR_REQ -> no i2c_start; start pulses the cycle after ready rises.
REQ-024 Retry: write NACKed twice, then ACK -> three write starts, flag=01 during retries, then 00 after UPDATE.
REQ-025 Error: read NACKed three times -> three read starts, flag=10, bin unchanged, no bin_valid, PERIOD entered.
REQ-026 Disable mid-read: enable=0 in RD_WAIT -> read completes, bin updates, then IDLE with busy=0 and no further starts.
REQ-027 Sync reset during CONV -> next cycle all outputs at REQ-020 values; a late i2c_done causes no state change.

Source files
------------

// File: rtl/i2c_sensor_seq.sv
// Periodic I2C sensor sequencer: writes a measurement command, waits for the
// conversion, reads the result and publishes it, retrying NACKed phases.
module i2c_sensor_seq #(
    parameter logic [6:0]  SLAVE_ADDR    = 7'h44,
    parameter logic [15:0] MEAS_CMD      = 16'h2C06,
    parameter logic [2:0]  RD_BYTES      = 3'd2,
    parameter logic [15:0] CONV_CYCLES   = 16'd6000,
    parameter logic [23:0] PERIOD_CYCLES = 24'd5000000,
    parameter logic [1:0]  MAX_RETRY     = 2'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        i2c_ready,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic [15:0] i2c_rdata,
    output logic        i2c_start,
    output logic [6:0]  slave_addr,
    output logic        cmd_byte,
    output logic [15:0] i2c_cmd,
    output logic [2:0]  data_byte,
    output logic [15:0] bin,
    output logic        bin_valid,
    output logic        busy,
    output logic [1:0]  flag
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, CONV, RD_REQ, RD_WAIT, UPDATE, PERIOD
    } state_t;

    // A zero delay is treated as a single cycle so both waits always end.
    localparam logic [23:0] CONV_LOAD   = (CONV_CYCLES == 16'd0) ? 24'd1 : {8'd0, CONV_CYCLES};
    localparam logic [23:0] PERIOD_LOAD = (PERIOD_CYCLES == 24'd0) ? 24'd1 : PERIOD_CYCLES;

    state_t      state, next_state;
    logic [23:0] dly_cnt;
    logic [1:0]  retry_cnt;
    logic [15:0] rdata_p0;
    logic        xfer_ok, retry_inc, final_nack;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'b01;
    endfunction

    function automatic logic [23:0] sat_dec24(input logic [23:0] v);
        return (v == 24'd0) ? v : v - 24'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Only the WAIT states ignore enable, so an in-flight transaction always completes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = WR_REQ;
            WR_REQ:  if (!enable) next_state = IDLE;
                     else if (i2c_ready) next_state = WR_WAIT;
            WR_WAIT: if (i2c_done) begin
                         if (!i2c_nack) next_state = CONV;
                         else if (retry_cnt < MAX_RETRY) next_state = WR_REQ;
                         else next_state = PERIOD;
                     end
            CONV:    if (!enable) next_state = IDLE;
                     else if (dly_cnt <= 24'd1) next_state = RD_REQ;
            RD_REQ:  if (!enable) next_state = IDLE;
                     else if (i2c_ready) next_state = RD_WAIT;
            RD_WAIT: if (i2c_done) begin
                         if (!i2c_nack) next_state = UPDATE;
                         else if (retry_cnt < MAX_RETRY) next_state = RD_REQ;
                         else next_state = PERIOD;
                     end
            UPDATE:  next_state = enable ? PERIOD : IDLE;
            PERIOD:  if (!enable) next_state = IDLE;
                     else if (dly_cnt <= 24'd1) next_state = WR_REQ;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        i2c_start  = 1'b0;
        busy       = (state != IDLE);
        xfer_ok    = 1'b0;
        retry_inc  = 1'b0;
        final_nack = 1'b0;
        case (state)
            WR_REQ:  i2c_start = (next_state == WR_WAIT);
            RD_REQ:  i2c_start = (next_state == RD_WAIT);
            WR_WAIT, RD_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_nack)                  xfer_ok    = 1'b1;
                    else if (retry_cnt < MAX_RETRY) retry_inc  = 1'b1;
                    else                            final_nack = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Read-data capture at the good read completion
    always_ff @(posedge clk) begin
        if (state == RD_WAIT && xfer_ok) rdata_p0 <= i2c_rdata;
    end

    // Control, counters and transaction fields; fields load on entry to a REQ
    // state so they are already stable in the cycle i2c_start fires.
    always_ff @(posedge clk) begin
        if (!rst) begin
            retry_cnt  <= 2'b00;
            dly_cnt    <= 24'd0;
            flag       <= 2'b00;
            bin        <= 16'h0000;
            bin_valid  <= 1'b0;
            cmd_byte   <= 1'b0;
            i2c_cmd    <= 16'h0000;
            data_byte  <= 3'd0;
            slave_addr <= SLAVE_ADDR;
        end else begin
            bin_valid <= 1'b0;

            if (retry_inc) begin
                retry_cnt <= sat_inc2(retry_cnt);
                flag      <= 2'b01;
            end else if (state == IDLE || state == CONV || state == PERIOD) begin
                retry_cnt <= 2'b00;
            end
            if (final_nack) flag <= 2'b10;

            if (next_state == CONV && state != CONV)          dly_cnt <= CONV_LOAD;
            else if (next_state == PERIOD && state != PERIOD) dly_cnt <= PERIOD_LOAD;
            else                                              dly_cnt <= sat_dec24(dly_cnt);

            if (next_state == WR_REQ) begin
                slave_addr <= SLAVE_ADDR;
                cmd_byte   <= 1'b1;
                i2c_cmd    <= MEAS_CMD;
                data_byte  <= 3'd0;
            end else if (next_state == RD_REQ) begin
                slave_addr <= SLAVE_ADDR;
                cmd_byte   <= 1'b0;
                data_byte  <= RD_BYTES;
            end

            if (state == UPDATE) begin
                bin       <= (RD_BYTES == 3'd1) ? {8'h00, rdata_p0[15:8]} : rdata_p0;
                bin_valid <= 1'b1;
                flag      <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_i2c_sensor_seq.sv
// Directed bench for i2c_sensor_seq with short conversion/period delays.
module tb_i2c_sensor_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        i2c_ready = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic [15:0] i2c_rdata = 16'h0000;
    logic        i2c_start;
    logic [6:0]  slave_addr;
    logic        cmd_byte;
    logic [15:0] i2c_cmd;
    logic [2:0]  data_byte;
    logic [15:0] bin;
    logic        bin_valid;
    logic        busy;
    logic [1:0]  flag;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;
    int n_start = 0;
    int n_rd = 0;
    int n_bv = 0;

    i2c_sensor_seq #(
        .CONV_CYCLES  (16'd4),
        .PERIOD_CYCLES(24'd20),
        .MAX_RETRY    (2'd2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .i2c_ready (i2c_ready),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .i2c_rdata (i2c_rdata),
        .i2c_start (i2c_start),
        .slave_addr(slave_addr),
        .cmd_byte  (cmd_byte),
        .i2c_cmd   (i2c_cmd),
        .data_byte (data_byte),
        .bin       (bin),
        .bin_valid (bin_valid),
        .busy      (busy),
        .flag      (flag)
    );

    always #5 clk = ~clk;

    // Event counters see the cycle that just ended at each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i2c_start === 1'b1) begin
            n_start <= n_start + 1;
            if (cmd_byte === 1'b0) n_rd <= n_rd + 1;
        end
        if (bin_valid === 1'b1) n_bv <= n_bv + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic wait_start(input int budget, output bit ok, output int at);
        ok = 1'b0; at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i2c_start === 1'b1) begin ok = 1'b1; at = cyc; break; end
        end
    endtask

    task automatic wait_bv(input int budget, output bit ok, output int at);
        ok = 1'b0; at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bin_valid === 1'b1) begin ok = 1'b1; at = cyc; break; end
        end
    endtask

    // Pulses i2c_done 'dly' cycles later; 'at' is the cycle holding the pulse.
    task automatic respond(input int dly, input logic nack, input logic [15:0] data, output int at);
        step(dly);
        i2c_done = 1'b1; i2c_nack = nack; i2c_rdata = data; at = cyc;
        step(1);
        i2c_done = 1'b0; i2c_nack = 1'b0;
    endtask

    task automatic test_reset();
        int s0;
        rst = 1'b0; enable = 1'b1; i2c_ready = 1'b1;
        step(3);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b want 0", busy); end else passed++;
        checks++; if (i2c_start !== 1'b0) begin failed++; $display("FAIL rst_start: got %b want 0", i2c_start); end else passed++;
        checks++; if (bin_valid !== 1'b0) begin failed++; $display("FAIL rst_bin_valid: got %b want 0", bin_valid); end else passed++;
        checks++; if (flag !== 2'b00) begin failed++; $display("FAIL rst_flag: got %b want 00", flag); end else passed++;
        checks++; if (bin !== 16'h0000) begin failed++; $display("FAIL rst_bin: got %h want 0000", bin); end else passed++;
        checks++; if (cmd_byte !== 1'b0) begin failed++; $display("FAIL rst_cmd_byte: got %b want 0", cmd_byte); end else passed++;
        checks++; if (i2c_cmd !== 16'h0000) begin failed++; $display("FAIL rst_i2c_cmd: got %h want 0000", i2c_cmd); end else passed++;
        checks++; if (data_byte !== 3'd0) begin failed++; $display("FAIL rst_data_byte: got %0d want 0", data_byte); end else passed++;
        checks++; if (slave_addr !== 7'h44) begin failed++; $display("FAIL rst_slave_addr: got %h want 44", slave_addr); end else passed++;
        step(1);
        enable = 1'b0; rst = 1'b1; s0 = n_start;
        step(5);
        checks++; if (busy !== 1'b0) begin failed++; $display("FAIL idle_busy: got %b want 0", busy); end else passed++;
        checks++; if (n_start !== s0) begin failed++; $display("FAIL idle_no_start: got %0d starts want 0", n_start - s0); end else passed++;
    endtask

    task automatic test_nominal();
        bit ok; int ws, wd, rs, rd, bv, ws2, s0, b0;
        do_reset(); i2c_ready = 1'b1; s0 = n_start; b0 = n_bv;
        enable = 1'b1;
        wait_start(10, ok, ws);
        checks++; if (ok !== 1'b1) begin failed++; $display("FAIL nom_wr_start: got none want start"); end else passed++;
        checks++; if (cmd_byte !== 1'b1) begin failed++; $display("FAIL nom_wr_cmd_byte: got %b want 1", cmd_byte); end else passed++;
        checks++; if (i2c_cmd !== 16'h2C06) begin failed++; $display("FAIL nom_wr_cmd: got %h want 2c06", i2c_cmd); end else passed++;
        checks++; if (slave_addr !== 7'h44) begin failed++; $display("FAIL nom_addr: got %h want 44", slave_addr); end else passed++;
        // lone NACK without done must not disturb the write
        step(3); i2c_nack = 1'b1; step(1); i2c_nack = 1'b0;
        respond(6, 1'b0, 16'h0000, wd);
        checks++; if (i2c_cmd !== 16'h2C06) begin failed++; $display("FAIL nom_cmd_held: got %h want 2c06", i2c_cmd); end else passed++;
        wait_start(20, ok, rs);
        // four CONV cycles lie between the done cycle and the read start cycle
        checks++; if (rs !== wd + 5) begin failed++; $display("FAIL nom_rd_timing: got cycle %0d want %0d", rs, wd + 5); end else passed++;
        checks++; if (cmd_byte !== 1'b0 || data_byte !== 3'd2) begin failed++; $display("FAIL nom_rd_fields: got cmd_byte=%b data_byte=%0d want 0/2", cmd_byte, data_byte); end else passed++;
        checks++; if (flag !== 2'b00) begin failed++; $display("FAIL nom_flag: got %b want 00", flag); end else passed++;
        respond(10, 1'b0, 16'h6A3C, rd);
        wait_bv(10, ok, bv);
        checks++; if (bv !== rd + 2) begin failed++; $display("FAIL nom_bv_timing: got cycle %0d want %0d", bv, rd + 2); end else passed++;
        checks++; if (bin !== 16'h6A3C) begin failed++; $display("FAIL nom_bin: got %h want 6a3c", bin); end else passed++;
        wait_start(40, ok, ws2);
        checks++; if (ws2 !== bv + 20) begin failed++; $display("FAIL nom_period: got cycle %0d want %0d", ws2, bv + 20); end else passed++;
        step(1);
        checks++; if (n_bv - b0 !== 1) begin failed++; $display("FAIL nom_bv_count: got %0d want 1", n_bv - b0); end else passed++;
        checks++; if (n_start - s0 !== 3) begin failed++; $display("FAIL nom_start_count: got %0d want 3", n_start - s0); end else passed++;
    endtask

    task automatic test_ready_stall();
        int s0;
        do_reset(); i2c_ready = 1'b0; s0 = n_start;
        enable = 1'b1;
        step(1);
        step(15);
        checks++; if (n_start !== s0) begin failed++; $display("FAIL stall_no_start: got %0d starts want 0", n_start - s0); end else passed++;
        checks++; if (busy !== 1'b1) begin failed++; $display("FAIL stall_busy: got %b want 1", busy); end else passed++;
        i2c_ready = 1'b1;
        @(negedge clk);
        checks++; if (i2c_start !== 1'b1) begin failed++; $display("FAIL stall_release_start: got %b want 1", i2c_start); end else passed++;
        checks++; if (cmd_byte !== 1'b1 || i2c_cmd !== 16'h2C06) begin failed++; $display("FAIL stall_fields: got %b/%h want 1/2c06", cmd_byte, i2c_cmd); end else passed++;
        step(1);
        @(negedge clk);
        checks++; if (i2c_start !== 1'b0) begin failed++; $display("FAIL stall_single_pulse: got %b want 0", i2c_start); end else passed++;
    endtask

    task automatic test_retry();
        bit ok; int t, d, s0;
        do_reset(); i2c_ready = 1'b1; s0 = n_start;
        enable = 1'b1;
        wait_start(10, ok, t);
        respond(3, 1'b1, 16'h0000, d);
        checks++; if (flag !== 2'b01) begin failed++; $display("FAIL retry_flag1: got %b want 01", flag); end else passed++;
        wait_start(10, ok, t);
        checks++; if (ok !== 1'b1 || cmd_byte !== 1'b1) begin failed++; $display("FAIL retry_wr2: got ok=%b cmd_byte=%b want 1/1", ok, cmd_byte); end else passed++;
        respond(3, 1'b1, 16'h0000, d);
        checks++; if (flag !== 2'b01) begin failed++; $display("FAIL retry_flag2: got %b want 01", flag); end else passed++;
        wait_start(10, ok, t);
        respond(3, 1'b0, 16'h0000, d);
        step(2);
        checks++; if (flag !== 2'b01) begin failed++; $display("FAIL retry_flag_conv: got %b want 01", flag); end else passed++;
        checks++; if (n_start - s0 !== 3) begin failed++; $display("FAIL retry_wr_count: got %0d want 3", n_start - s0); end else passed++;
        wait_start(20, ok, t);
        checks++; if (ok !== 1'b1 || cmd_byte !== 1'b0) begin failed++; $display("FAIL retry_rd_start: got ok=%b cmd_byte=%b want 1/0", ok, cmd_byte); end else passed++;
        respond(2, 1'b0, 16'h1234, d);
        wait_bv(10, ok, t);
        checks++; if (flag !== 2'b00) begin failed++; $display("FAIL retry_flag_clear: got %b want 00", flag); end else passed++;
        checks++; if (bin !== 16'h1234) begin failed++; $display("FAIL retry_bin: got %h want 1234", bin); end else passed++;
    endtask

    // Continues from test_retry: bin holds 1234 and the period is running.
    task automatic test_error();
        bit ok; int t, d, r0, b0;
        step(1);
        r0 = n_rd; b0 = n_bv;
        wait_start(40, ok, t);
        checks++; if (ok !== 1'b1 || cmd_byte !== 1'b1) begin failed++; $display("FAIL err_wr_start: got ok=%b cmd_byte=%b want 1/1", ok, cmd_byte); end else passed++;
        respond(3, 1'b0, 16'h0000, d);
        for (int k = 0; k < 3; k++) begin
            wait_start(20, ok, t);
            respond(3, 1'b1, 16'hDEAD, d);
        end
        checks++; if (n_rd - r0 !== 3) begin failed++; $display("FAIL err_rd_count: got %0d want 3", n_rd - r0); end else passed++;
        checks++; if (flag !== 2'b10) begin failed++; $display("FAIL err_flag: got %b want 10", flag); end else passed++;
        checks++; if (bin !== 16'h1234) begin failed++; $display("FAIL err_bin_kept: got %h want 1234", bin); end else passed++;
        checks++; if (n_bv !== b0) begin failed++; $display("FAIL err_no_bv: got %0d pulses want 0", n_bv - b0); end else passed++;
        checks++; if (busy !== 1'b1) begin failed++; $display("FAIL err_busy: got %b want 1", busy); end else passed++;
        wait_start(40, ok, t);
        checks++; if (t !== d + 21) begin failed++; $display("FAIL err_period: got cycle %0d want %0d", t, d + 21); end else passed++;
    endtask

    task automatic test_disable_mid_read();
        bit ok; int t, d, s0;
        do_reset(); i2c_ready = 1'b1;
        enable = 1'b1;
        wait_start(10, ok, t);
        respond(3, 1'b0, 16'h0000, d);
        wait_start(20, ok, t);
        step(1);
        enable = 1'b0; s0 = n_start;
        respond(2, 1'b0, 16'hBEEF, d);
        wait_bv(10, ok, t);
        checks++; if (ok !== 1'b1 || bin !== 16'hBEEF) begin failed++; $display("FAIL dis_bin: got ok=%b bin=%h want 1/beef", ok, bin); end else passed++;
        checks++; if (busy !== 1'b0) begin failed++; $display("FAIL dis_idle: got busy=%b want 0", busy); end else passed++;
        step(40);
        checks++; if (n_start !== s0) begin failed++; $display("FAIL dis_no_start: got %0d starts want 0", n_start - s0); end else passed++;
        checks++; if (bin !== 16'hBEEF || busy !== 1'b0) begin failed++; $display("FAIL dis_hold: got bin=%h busy=%b want beef/0", bin, busy); end else passed++;
    endtask

    task automatic test_reset_in_conv();
        bit ok; int t, d, s0, b0;
        do_reset(); i2c_ready = 1'b1;
        enable = 1'b1;
        wait_start(10, ok, t);
        respond(3, 1'b0, 16'h0000, d);
        step(1);
        rst = 1'b0; enable = 1'b0;
        step(1);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || i2c_start !== 1'b0 || bin_valid !== 1'b0) begin failed++; $display("FAIL rconv_ctrl: got busy=%b start=%b bv=%b want 0/0/0", busy, i2c_start, bin_valid); end else passed++;
        checks++; if (cmd_byte !== 1'b0 || i2c_cmd !== 16'h0000 || data_byte !== 3'd0) begin failed++; $display("FAIL rconv_fields: got %b/%h/%0d want 0/0000/0", cmd_byte, i2c_cmd, data_byte); end else passed++;
        checks++; if (flag !== 2'b00 || bin !== 16'h0000 || slave_addr !== 7'h44) begin failed++; $display("FAIL rconv_status: got flag=%b bin=%h addr=%h want 00/0000/44", flag, bin, slave_addr); end else passed++;
        step(1);
        s0 = n_start; b0 = n_bv;
        step(2); i2c_done = 1'b1; step(1); i2c_done = 1'b0;
        step(20);
        checks++; if (busy !== 1'b0 || n_start !== s0 || n_bv !== b0) begin failed++; $display("FAIL rconv_stray_done: got busy=%b starts=%0d bv=%0d want 0/0/0", busy, n_start - s0, n_bv - b0); end else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ready_stall();
        test_retry();
        test_error();
        test_disable_mid_read();
        test_reset_in_conv();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
